instr_queue: RTL and testbench

//  Dual-entry-per-cycle instruction FIFO between fetch and decode. Accepts up to two
//  32-bit instructions per cycle from fetch, holds them in order, and presents the two

---
 rtl/instr_queue.sv | 102 ++++++++++
 tb/tb_instr_queue.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/instr_queue.sv
// Dual-entry-per-cycle instruction FIFO between fetch and decode (two pushes, up to two pops per cycle).
// Optional: define IQ_STALL_CNT_EN to add a saturating fetch-stall counter output stall_cnt.
module instr_queue #(
  parameter int DEPTH = 8,
  parameter int IW    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    fetch_valid1,
  input  logic [IW-1:0]           fetch_instr1,
  input  logic                    fetch_valid2,
  input  logic [IW-1:0]           fetch_instr2,
  output logic                    fetch_ready,
  output logic [IW-1:0]           new_instr1_out,
  output logic                    new_instr1_valid,
  output logic [IW-1:0]           new_instr2_out,
  output logic                    new_instr2_valid,
  input  logic [1:0]              dec_take,
  output logic [$clog2(DEPTH):0]  count
`ifdef IQ_STALL_CNT_EN
  ,
  output logic [15:0]             stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

  logic [IW-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, rd_ptr_p1;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, wr_ptr_p1;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    n_push, n_pop, take_sat;

  assign rd_ptr_p1   = rd_ptr_q + AW'(1);
  assign wr_ptr_p1   = wr_ptr_q + AW'(1);
  assign fetch_ready = (count_q <= READY_MAX);

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    n_push = 2'd0;
    if (fetch_ready && fetch_valid1) begin
      n_push = fetch_valid2 ? 2'd2 : 2'd1;
    end
    take_sat = (dec_take == 2'd3) ? 2'd2 : dec_take;
    n_pop    = (count_q < CW'(take_sat)) ? count_q[1:0] : take_sat;
    rd_ptr_d = rd_ptr_q + AW'(n_pop);
    wr_ptr_d = wr_ptr_q + AW'(n_push);
    count_d  = count_q + CW'(n_push) - CW'(n_pop);
  end

  // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; occupancy gates every read, so old contents are never observed.
  always_ff @(posedge clk) begin
    if (!rst && !flush && n_push != 2'd0) begin
      mem_q[wr_ptr_q] <= fetch_instr1;
      if (n_push == 2'd2) begin
        mem_q[wr_ptr_p1] <= fetch_instr2;
      end
    end
  end

  assign new_instr1_valid = (count_q != '0);
  assign new_instr2_valid = (count_q >= CW'(2));
  assign new_instr1_out   = new_instr1_valid ? mem_q[rd_ptr_q]  : '0;
  assign new_instr2_out   = new_instr2_valid ? mem_q[rd_ptr_p1] : '0;
  assign count            = count_q;

`ifdef IQ_STALL_CNT_EN
  // Counts cycles fetch had an instruction ready but was held off; survives flush.
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (fetch_valid1 && !fetch_ready && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_queue.sv
// Scoreboard bench for instr_queue: a queue-based reference model predicts each post-edge state,
// and a decoupled monitor compares the DUT outputs against those predictions.
module tb_instr_queue;

  localparam int DEPTH = 8;
  localparam int IW    = 32;

  typedef struct {
    logic [31:0] o1;
    logic [31:0] o2;
    logic        v1;
    logic        v2;
    logic        rdy;
    logic [3:0]  cnt;
    logic [15:0] stall;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          fetch_valid1;
  logic [IW-1:0] fetch_instr1;
  logic          fetch_valid2;
  logic [IW-1:0] fetch_instr2;
  logic          fetch_ready;
  logic [IW-1:0] new_instr1_out;
  logic          new_instr1_valid;
  logic [IW-1:0] new_instr2_out;
  logic          new_instr2_valid;
  logic [1:0]    dec_take;
  logic [3:0]    count;
`ifdef IQ_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  logic [31:0] mq[$];
  int          stall_m = 0;
  exp_t        exp_q[$];

  instr_queue #(.DEPTH(DEPTH), .IW(IW)) dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .fetch_valid1     (fetch_valid1),
    .fetch_instr1     (fetch_instr1),
    .fetch_valid2     (fetch_valid2),
    .fetch_instr2     (fetch_instr2),
    .fetch_ready      (fetch_ready),
    .new_instr1_out   (new_instr1_out),
    .new_instr1_valid (new_instr1_valid),
    .new_instr2_out   (new_instr2_out),
    .new_instr2_valid (new_instr2_valid),
    .dec_take         (dec_take),
    .count            (count)
`ifdef IQ_STALL_CNT_EN
    ,
    .stall_cnt        (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of instructions; occupancy is just its size.
  task automatic model(input logic r, input logic f, input logic fv1, input logic [31:0] i1,
                       input logic fv2, input logic [31:0] i2, input logic [1:0] take);
    int   n;
    bit   rdy;
    exp_t e;
    if (r) begin
      mq.delete();
      stall_m = 0;
    end else begin
      rdy = (mq.size() <= DEPTH - 2);
      if (fv1 && !rdy && stall_m < 65535) stall_m++;
      if (f) begin
        mq.delete();
      end else begin
        n = (take == 2'd3) ? 2 : int'(take);
        while (n > 0 && mq.size() > 0) begin
          void'(mq.pop_front());
          n--;
        end
        if (rdy && fv1) begin
          mq.push_back(i1);
          if (fv2) mq.push_back(i2);
        end
      end
    end
    e.cnt   = 4'(mq.size());
    e.v1    = (mq.size() >= 1);
    e.v2    = (mq.size() >= 2);
    e.o1    = (mq.size() >= 1) ? mq[0] : 32'h0;
    e.o2    = (mq.size() >= 2) ? mq[1] : 32'h0;
    e.rdy   = (mq.size() <= DEPTH - 2);
    e.stall = 16'(stall_m);
    exp_q.push_back(e);
  endtask

  task automatic step(input logic r, input logic f, input logic fv1, input logic [31:0] i1,
                      input logic fv2, input logic [31:0] i2, input logic [1:0] take);
    rst          = r;
    flush        = f;
    fetch_valid1 = fv1;
    fetch_instr1 = i1;
    fetch_valid2 = fv2;
    fetch_instr2 = i2;
    dec_take     = take;
    model(r, f, fv1, i1, fv2, i2, take);
    @(posedge clk);
    #3;
  endtask

  task automatic push_pair(input logic [1:0] take);
    step(1'b0, 1'b0, 1'b1, $urandom, 1'b1, $urandom, take);
  endtask

  // Monitor: compares each post-edge DUT state against the next scoreboard entry.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("count",       32'(count),            32'(e.cnt));
      check("valid1",      32'(new_instr1_valid), 32'(e.v1));
      check("valid2",      32'(new_instr2_valid), 32'(e.v2));
      check("instr1",      new_instr1_out,        e.o1);
      check("instr2",      new_instr2_out,        e.o2);
      check("fetch_ready", 32'(fetch_ready),      32'(e.rdy));
`ifdef IQ_STALL_CNT_EN
      check("stall_cnt",   32'(stall_cnt),        32'(e.stall));
`endif
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held for two cycles.
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 2'd0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 2'd0);

    // Single pair, then drain one at a time with an over-take at count=1.
    step(1'b0, 1'b0, 1'b1, 32'h8123_0000, 1'b1, 32'h4560_8000, 2'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 2'd1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 2'd2);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 2'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 2'd3);

    // Fill to full, hold a fifth pair, then pop with the pair still offered.
    repeat (4) push_pair(2'd0);
    repeat (3) step(1'b0, 1'b0, 1'b1, 32'hCAFE_0001, 1'b1, 32'hCAFE_0002, 2'd0);
    step(1'b0, 1'b0, 1'b1, 32'hCAFE_0001, 1'b1, 32'hCAFE_0002, 2'd1);
    step(1'b0, 1'b0, 1'b1, 32'hCAFE_0001, 1'b1, 32'hCAFE_0002, 2'd1);
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 2'd2);

    // Steady push-2/take-2 at count=2 across pointer wrap.
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 2'd0);
    push_pair(2'd0);
    repeat (20) push_pair(2'd2);

    // Flush at count=5 with a simultaneous push and take.
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 2'd0);
    push_pair(2'd0);
    push_pair(2'd0);
    step(1'b0, 1'b0, 1'b1, $urandom, 1'b0, 32'h0, 2'd0);
    step(1'b0, 1'b1, 1'b1, $urandom, 1'b1, $urandom, 2'd2);
    push_pair(2'd0);
    step(1'b1, 1'b1, 1'b1, $urandom, 1'b1, $urandom, 2'd1);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 19) == 0),
           1'($urandom), $urandom, 1'($urandom), $urandom, 2'($urandom_range(0, 3)));
    end
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 2'd0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
